// File: rtl/rc5_pkg.sv
// Shared types and frame layout for the rc5 validation scan responder.
// Default widths give a 168-bit command frame and a 33-bit result chain.
package rc5_pkg;

  localparam int DEF_KEY_W    = 128;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ROUNDS_W = 5;
  localparam int DEF_TIMEOUT  = 1023;

  localparam int IN_LEN  = DEF_KEY_W + DEF_DATA_W + DEF_ROUNDS_W + 3;
  localparam int OUT_LEN = DEF_DATA_W + 1;

  localparam int FR_LOAD = 165;
  localparam int FR_ENC  = 166;
  localparam int FR_DEC  = 167;

  typedef enum logic [1:0] {IDLE, APPLY, WAIT, HOLD} scan_state_t;

  typedef enum logic [1:0] {OP_NONE, OP_LOAD, OP_ENC, OP_DEC} op_t;

  // cmd = {start_decrypt, start_encrypt, load_key}; anything but one-hot is no operation
  function automatic op_t decode_cmd(input logic [2:0] cmd);
    case (cmd)
      3'b001:  return OP_LOAD;
      3'b010:  return OP_ENC;
      3'b100:  return OP_DEC;
      default: return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/rc5_scan_ctrl_if.sv
// Scan-pin and rc5-core signal bundle; slave is the responder, master the tester/core side.
interface rc5_scan_ctrl_if import rc5_pkg::*; #(
  parameter int KEY_W    = DEF_KEY_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ROUNDS_W = DEF_ROUNDS_W
);

  logic                scan_en;
  logic                scan_in;
  logic                begin_validate;
  logic                scan_out;
  logic [KEY_W-1:0]    core_key;
  logic [DATA_W-1:0]   core_d_in;
  logic [ROUNDS_W-1:0] core_num_rounds;
  logic                core_load_key;
  logic                core_start_encrypt;
  logic                core_start_decrypt;
  logic [DATA_W-1:0]   core_d_out;
  logic                core_done;
  logic                core_key_ready;

  modport slave (
    input  scan_en, scan_in, begin_validate,
    input  core_d_out, core_done, core_key_ready,
    output scan_out, core_key, core_d_in, core_num_rounds,
    output core_load_key, core_start_encrypt, core_start_decrypt
  );

  modport master (
    output scan_en, scan_in, begin_validate,
    output core_d_out, core_done, core_key_ready,
    input  scan_out, core_key, core_d_in, core_num_rounds,
    input  core_load_key, core_start_encrypt, core_start_decrypt
  );

endinterface

// File: rtl/rc5_scan_shreg.sv
// Shift register: serial in at bit 0, parallel load has priority over shift.
// tap exposes the top PAR_W bits; tap[PAR_W-1] is the serial (MSB) output.
module rc5_scan_shreg #(
  parameter int W     = 8,
  parameter int PAR_W = W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             ser_in,
  input  logic             load_en,
  input  logic [W-1:0]     load_dat,
  output logic [PAR_W-1:0] tap
);

  logic [W-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (load_en) begin
      sr <= load_dat;
    end else if (shift_en) begin
      sr <= {sr[W-2:0], ser_in};
    end
  end

  assign tap = sr[W-1 -: PAR_W];

endmodule

// File: rtl/rc5_scan_ctrl.sv
// Scan responder: applies a shifted-in command frame to the rc5 core on a begin_validate edge,
// pulses the core one cycle after launch and captures {ok, d_out} on the completion edge or timeout.
module rc5_scan_ctrl import rc5_pkg::*; #(
  parameter int KEY_W    = DEF_KEY_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ROUNDS_W = DEF_ROUNDS_W,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input logic            clk,
  input logic            rst,
  rc5_scan_ctrl_if.slave bus
);

  localparam int FRAME_LEN = KEY_W + DATA_W + ROUNDS_W + 3;
  localparam int RES_LEN   = DATA_W + 1;
  localparam int B_LOAD    = KEY_W + DATA_W + ROUNDS_W;
  localparam int B_ENC     = B_LOAD + 1;
  localparam int B_DEC     = B_LOAD + 2;
  localparam int TMR_W     = $clog2(TIMEOUT + 1);

  scan_state_t state_q, state_d;
  op_t         op_q, op_frame;

  logic                bv_q, kr_q, dn_q;
  logic [TMR_W-1:0]    timer_q;
  logic [KEY_W-1:0]    key_q;
  logic [DATA_W-1:0]   din_q;
  logic [ROUNDS_W-1:0] rounds_q;

  logic [FRAME_LEN-1:0] in_q;
  logic                 out_msb;

  logic               launch, complete, timed_out;
  logic               in_shift, out_shift, out_load;
  logic [RES_LEN-1:0] out_dat;
  logic               pulse_load, pulse_enc, pulse_dec;

  assign launch    = bus.begin_validate & ~bv_q;
  assign op_frame  = decode_cmd({in_q[B_DEC], in_q[B_ENC], in_q[B_LOAD]});
  // Only a fresh rising edge counts; a level left high by a previous op is ignored
  assign complete  = (op_q == OP_LOAD) ? (bus.core_key_ready & ~kr_q)
                                       : (bus.core_done & ~dn_q);
  assign timed_out = (timer_q == TMR_W'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = APPLY;
      APPLY:   state_d = (op_q == OP_NONE) ? HOLD : WAIT;
      WAIT:    if (complete || timed_out) state_d = HOLD;
      HOLD:    if (!bus.begin_validate) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pulse_load = 1'b0;
    pulse_enc  = 1'b0;
    pulse_dec  = 1'b0;
    out_load   = 1'b0;
    out_dat    = '0;
    in_shift   = bus.scan_en && (state_q == IDLE);
    out_shift  = bus.scan_en && ((state_q == IDLE) || (state_q == HOLD));
    case (state_q)
      APPLY: begin
        pulse_load = (op_q == OP_LOAD);
        pulse_enc  = (op_q == OP_ENC);
        pulse_dec  = (op_q == OP_DEC);
        out_load   = (op_q == OP_NONE);
      end
      WAIT: begin
        if (complete) begin
          out_load = 1'b1;
          out_dat  = {1'b1, (op_q == OP_LOAD) ? {DATA_W{1'b0}} : bus.core_d_out};
        end else if (timed_out) begin
          out_load = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bv_q     <= 1'b0;
      kr_q     <= 1'b0;
      dn_q     <= 1'b0;
      timer_q  <= '0;
      key_q    <= '0;
      din_q    <= '0;
      rounds_q <= '0;
      op_q     <= OP_NONE;
    end else begin
      bv_q <= bus.begin_validate;
      kr_q <= bus.core_key_ready;
      dn_q <= bus.core_done;
      if ((state_q == IDLE) && launch) begin
        key_q    <= in_q[KEY_W-1:0];
        din_q    <= in_q[KEY_W +: DATA_W];
        rounds_q <= in_q[KEY_W+DATA_W +: ROUNDS_W];
        op_q     <= op_frame;
      end
      if (state_q == APPLY) begin
        timer_q <= '0;
      end else if ((state_q == WAIT) && !timed_out) begin
        timer_q <= timer_q + 1'b1;
      end
    end
  end

  rc5_scan_shreg #(.W(FRAME_LEN), .PAR_W(FRAME_LEN)) u_in_sr (
    .clk      (clk),
    .rst      (rst),
    .shift_en (in_shift),
    .ser_in   (bus.scan_in),
    .load_en  (1'b0),
    .load_dat ({FRAME_LEN{1'b0}}),
    .tap      (in_q)
  );

  rc5_scan_shreg #(.W(RES_LEN), .PAR_W(1)) u_out_sr (
    .clk      (clk),
    .rst      (rst),
    .shift_en (out_shift),
    .ser_in   (1'b0),
    .load_en  (out_load),
    .load_dat (out_dat),
    .tap      (out_msb)
  );

  assign bus.scan_out           = out_msb;
  assign bus.core_key           = key_q;
  assign bus.core_d_in          = din_q;
  assign bus.core_num_rounds    = rounds_q;
  assign bus.core_load_key      = pulse_load;
  assign bus.core_start_encrypt = pulse_enc;
  assign bus.core_start_decrypt = pulse_dec;

endmodule

// File: tb/tb_rc5_scan_ctrl.sv
// Bench for rc5_scan_ctrl: stub rc5 core, directed scan frames, queue-based scoreboard.
module tb_rc5_scan_ctrl;
  import rc5_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rc5_scan_ctrl_if bus ();

  rc5_scan_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [127:0] KEY = 128'h2B7E151628AED2A6ABF7158809CF4F3C;

  typedef struct {
    string        tag;
    logic [191:0] v;
  } item_t;

  item_t exp_q[$];
  item_t obs_q[$];
  item_t mon_o, mon_e;
  int    checks = 0;
  int    errors = 0;

  int n_load = 0, n_enc = 0, n_dec = 0;
  int b_load = 0, b_enc = 0, b_dec = 0;
  int kcnt = 0, dcnt = 0;
  bit hang = 1'b0;

  // Stub core plus pulse counters, evaluated away from the active edge
  always @(negedge clk) begin
    if (rst) begin
      bus.core_key_ready = 1'b0;
      bus.core_done      = 1'b0;
      bus.core_d_out     = '0;
      kcnt = 0;
      dcnt = 0;
    end else begin
      n_load += int'(bus.core_load_key);
      n_enc  += int'(bus.core_start_encrypt);
      n_dec  += int'(bus.core_start_decrypt);
      if (kcnt > 0) begin
        kcnt--;
        if (kcnt == 0) bus.core_key_ready = 1'b1;
      end
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) begin
          bus.core_done  = 1'b1;
          bus.core_d_out = bus.core_d_in ^ 32'hFFFFFFFF;
        end
      end
      if (!hang && bus.core_load_key) begin
        bus.core_key_ready = 1'b0;
        kcnt = 20;
      end
      if (!hang && (bus.core_start_encrypt || bus.core_start_decrypt)) begin
        bus.core_done  = 1'b0;
        bus.core_d_out = '0;
        dcnt = 12;
      end
    end
  end

  always @(negedge clk) begin
    while (obs_q.size() > 0) begin
      mon_o = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s got %h with nothing expected", mon_o.tag, mon_o.v);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.tag != mon_o.tag || mon_e.v !== mon_o.v) begin
          errors++;
          $display("FAIL %s got %h required %s %h", mon_o.tag, mon_o.v, mon_e.tag, mon_e.v);
        end
      end
    end
  end

  function automatic logic [167:0] mk_frame(input logic [2:0] cmd, input logic [4:0] rounds,
                                            input logic [31:0] d, input logic [127:0] key);
    logic [167:0] f;
    f = {3'b000, rounds, d, key};
    f[FR_LOAD] = cmd[0];
    f[FR_ENC]  = cmd[1];
    f[FR_DEC]  = cmd[2];
    return f;
  endfunction

  function automatic logic [191:0] outs_vec();
    return 192'({bus.scan_out, bus.core_start_decrypt, bus.core_start_encrypt, bus.core_load_key,
                 bus.core_num_rounds, bus.core_d_in, bus.core_key});
  endfunction

  task automatic expect_v(input string t, input logic [191:0] v);
    item_t it;
    it.tag = t;
    it.v   = v;
    exp_q.push_back(it);
  endtask

  task automatic observe(input string t, input logic [191:0] v);
    item_t it;
    it.tag = t;
    it.v   = v;
    obs_q.push_back(it);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scan_in_frame(input logic [167:0] f);
    for (int i = IN_LEN - 1; i >= 0; i--) begin
      @(negedge clk);
      bus.scan_in = f[i];
      bus.scan_en = 1'b1;
    end
    @(negedge clk);
    bus.scan_en = 1'b0;
    bus.scan_in = 1'b0;
  endtask

  task automatic scan_out_result(input string t, input logic [32:0] exp);
    logic [32:0] r;
    r = '0;
    expect_v(t, 192'(exp));
    for (int i = 0; i < OUT_LEN; i++) begin
      @(negedge clk);
      r = {r[31:0], bus.scan_out};
      bus.scan_en = 1'b1;
    end
    @(negedge clk);
    bus.scan_en = 1'b0;
    observe(t, 192'(r));
  endtask

  // Raise begin_validate; the pulse must be visible in the very next cycle
  task automatic launch(input string t, input logic [2:0] exp_pulse);
    b_load = n_load;
    b_enc  = n_enc;
    b_dec  = n_dec;
    expect_v(t, 192'(exp_pulse));
    @(negedge clk);
    bus.begin_validate = 1'b1;
    @(negedge clk);
    observe(t, 192'({bus.core_start_decrypt, bus.core_start_encrypt, bus.core_load_key}));
  endtask

  task automatic check_counts(input string t, input int el, input int ee, input int ed);
    expect_v(t, 192'({el, ee, ed}));
    observe(t, 192'({n_load - b_load, n_enc - b_enc, n_dec - b_dec}));
  endtask

  task automatic drop_bv();
    @(negedge clk);
    bus.begin_validate = 1'b0;
    wait_cycles(2);
  endtask

  initial begin
    rst = 1'b1;
    bus.scan_en = 1'b0;
    bus.scan_in = 1'b0;
    bus.begin_validate = 1'b0;
    wait_cycles(3);
    expect_v("rst_state", '0);
    observe("rst_state", outs_vec());
    rst = 1'b0;
    wait_cycles(2);

    // Key load
    scan_in_frame(mk_frame(3'b001, 5'd15, 32'h0, KEY));
    launch("t1_pulse", 3'b001);
    wait_cycles(40);
    check_counts("t1_cnt", 1, 0, 0);
    expect_v("t1_key", 192'(KEY));
    observe("t1_key", 192'(bus.core_key));
    expect_v("t1_rounds", 192'(5'd15));
    observe("t1_rounds", 192'(bus.core_num_rounds));
    scan_out_result("t1_res", 33'h1_00000000);
    drop_bv();

    // Encrypt
    scan_in_frame(mk_frame(3'b010, 5'd15, 32'hD87FAB42, KEY));
    launch("t2_pulse", 3'b010);
    wait_cycles(40);
    check_counts("t2_cnt", 0, 1, 0);
    expect_v("t2_din", 192'(32'hD87FAB42));
    observe("t2_din", 192'(bus.core_d_in));
    scan_out_result("t2_res", 33'h1_278054BD);
    drop_bv();

    // Decrypt
    scan_in_frame(mk_frame(3'b100, 5'd15, 32'hE460BA1B, KEY));
    launch("t3_pulse", 3'b100);
    wait_cycles(40);
    check_counts("t3_cnt", 0, 0, 1);
    expect_v("t3_key", 192'(KEY));
    observe("t3_key", 192'(bus.core_key));
    scan_out_result("t3_res", 33'h1_1B9F45E4);
    drop_bv();

    // Two command bits set, then no command bit set
    scan_in_frame(mk_frame(3'b110, 5'd15, 32'h55AA55AA, KEY));
    launch("t4_pulse", 3'b000);
    wait_cycles(5);
    check_counts("t4_cnt", 0, 0, 0);
    scan_out_result("t4_res", 33'h0_00000000);
    drop_bv();
    scan_in_frame(mk_frame(3'b000, 5'd15, 32'h55AA55AA, KEY));
    launch("t4b_pulse", 3'b000);
    wait_cycles(5);
    check_counts("t4b_cnt", 0, 0, 0);
    drop_bv();

    // Core never completes; done is left high from before, which must not count
    hang = 1'b1;
    scan_in_frame(mk_frame(3'b010, 5'd15, 32'hD87FAB42, KEY));
    launch("t5_pulse", 3'b010);
    wait_cycles(1100);
    check_counts("t5_cnt", 0, 1, 0);
    scan_out_result("t5_res", 33'h0_00000000);
    drop_bv();
    hang = 1'b0;

    // begin_validate held high long after completion: still a single pulse
    scan_in_frame(mk_frame(3'b010, 5'd7, 32'hD87FAB42, KEY));
    launch("t6_pulse", 3'b010);
    wait_cycles(80);
    check_counts("t6_cnt", 0, 1, 0);
    scan_out_result("t6_res", 33'h1_278054BD);
    drop_bv();

    // begin_validate dropped mid-WAIT: capture still happens, result read from IDLE
    scan_in_frame(mk_frame(3'b010, 5'd7, 32'h12345678, KEY));
    launch("t6b_pulse", 3'b010);
    wait_cycles(3);
    bus.begin_validate = 1'b0;
    wait_cycles(40);
    check_counts("t6b_cnt", 0, 1, 0);
    scan_out_result("t6b_res", 33'h1_EDCBA987);

    // Asynchronous reset mid-WAIT, then a normal operation
    scan_in_frame(mk_frame(3'b010, 5'd15, 32'hA5A5A5A5, KEY));
    launch("t7_pulse", 3'b010);
    wait_cycles(5);
    #2;
    rst = 1'b1;
    bus.begin_validate = 1'b0;
    #1;
    expect_v("t7_rst", '0);
    observe("t7_rst", outs_vec());
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(2);
    scan_in_frame(mk_frame(3'b100, 5'd15, 32'hE460BA1B, KEY));
    launch("t7_pulse2", 3'b100);
    wait_cycles(40);
    check_counts("t7_cnt", 0, 0, 1);
    expect_v("t7_key", 192'(KEY));
    observe("t7_key", 192'(bus.core_key));
    scan_out_result("t7_res", 33'h1_1B9F45E4);
    drop_bv();

    wait_cycles(3);
    checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain expected %0d observed %0d left, required 0 0",
               exp_q.size(), obs_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
